fb_scan_reader: RTL

Reads the Pong framebuffer out in raster order and streams pixels to the LCD pixel-write path. It is the read-side counterpart of the framebuffer address writers, which walk x/y to store pixels. On each frame request it walks y then x and issues framebuffer RAM reads at fixed 1-cycle latency. It delivers one pixel per handshake on a valid/ready stream, with start-of-frame and end-of-line markers, and absorbs sink backpressure in a 2-entry buffer.

---
 rtl/fb_scan_reader_pkg.sv | 8 +
 rtl/fb_scan_reader_if.sv | 13 +
 rtl/fb_pix_fifo2.sv | 34 +++
 rtl/fb_scan_reader.sv | 82 ++++++++
 4 files changed

// File: rtl/fb_scan_reader_pkg.sv
// fb_scan_reader_pkg: shared Pong screen geometry and scan-reader FSM state type
package fb_scan_reader_pkg;
    localparam int SCREEN_W  = 240;
    localparam int SCREEN_H  = 320;
    localparam int PIX_W     = 16;
    localparam int FB_ADDR_W = 17;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/fb_scan_reader_if.sv
// fb_scan_reader_if: framebuffer read port plus outgoing pixel stream
interface fb_scan_reader_if import fb_scan_reader_pkg::*; #(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = PIX_W
);
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid, pix_ready, pix_sof, pix_eol;
    modport master(output ram_rd, ram_addr, pix_data, pix_valid, pix_sof, pix_eol, input ram_rdata, pix_ready);
    modport slave(input ram_rd, ram_addr, pix_data, pix_valid, pix_sof, pix_eol, output ram_rdata, pix_ready);
endinterface

// File: rtl/fb_pix_fifo2.sv
// fb_pix_fifo2: two-entry FIFO carrying {last, eol, sof, data} for the scan reader
module fb_pix_fifo2 import fb_scan_reader_pkg::*; #(
    parameter int W = PIX_W + 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic wp, rp;
    assign rdata = mem[rp];
    assign empty = count == 2'd0;
    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr) begin
                mem[wp] <= wdata;
                wp      <= !wp;
            end
            if (rd) rp <= !rp;
            count <= count + {1'b0, wr} - {1'b0, rd};
        end
    end
endmodule

// File: rtl/fb_scan_reader.sv
// fb_scan_reader: raster-order framebuffer reader streaming pixels with sof/eol markers
// Reads have fixed 1-cycle latency; a 2-entry FIFO absorbs sink backpressure.
module fb_scan_reader import fb_scan_reader_pkg::*; #(
    parameter int X_MAX  = SCREEN_W - 1,
    parameter int Y_MAX  = SCREEN_H - 1,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = PIX_W
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic frame_done,
    fb_scan_reader_if.master bus
);
    localparam int XW = $clog2(X_MAX + 2);
    localparam int YW = $clog2(Y_MAX + 2);
    localparam logic [XW-1:0] XL = XW'(X_MAX);
    localparam logic [YW-1:0] YL = YW'(Y_MAX);
    state_t state, state_nx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ADDR_W-1:0] addr;
    logic inflight, issue, pop, empty, x_end, y_end;
    logic [2:0] flags;
    logic [1:0] count;
    logic [DATA_W+2:0] head;
    assign x_end = x == XL;
    assign y_end = y == YL;
    assign pop = !empty && bus.pix_ready;
    assign busy = state != IDLE;
    assign bus.ram_rd = issue;
    assign bus.ram_addr = addr;
    assign bus.pix_valid = !empty;
    assign bus.pix_data = head[DATA_W-1:0];
    assign bus.pix_sof = head[DATA_W];
    assign bus.pix_eol = head[DATA_W+1];
    // the budget counts the read in flight, so the FIFO can never overflow
    always_comb begin
        issue = state == RUN && ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
        state_nx = state;
        if (state == IDLE && start) state_nx = RUN;
        if (issue && x_end && y_end) state_nx = DRAIN;
        if (state == DRAIN && pop && head[DATA_W+2]) state_nx = IDLE;
    end
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : state_nx;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            inflight   <= 1'b0;
            flags      <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            inflight   <= issue;
            flags      <= {x_end && y_end, x_end, x == '0 && y == '0};
            frame_done <= state == DRAIN && state_nx == IDLE;
            if (state == IDLE && start) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end else if (issue) begin
                x    <= x_end ? '0 : x + XW'(1);
                y    <= y + YW'(x_end);
                addr <= addr + ADDR_W'(1);
            end
        end
    end
    fb_pix_fifo2 #(.W(DATA_W + 3)) u_fifo (
        .clock (clock),
        .reset (reset),
        .wr    (inflight),
        .wdata ({flags, bus.ram_rdata}),
        .rd    (pop),
        .rdata (head),
        .empty (empty),
        .count (count)
    );
endmodule
